// File: rtl/mem_bus_bridge_if.sv
// CPU-side request/response signals plus the flash and SRAM controller buses of the bridge.
// slave is the bridge's view; master is the view of the CPU and memory controllers around it.
interface mem_bus_bridge_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        cpu_busy;

    logic        mem_flash_cs;
    logic        mem_flash_rw;
    logic [24:0] mem_flash_addr;
    logic [31:0] mem_flash_data_wr;
    logic [31:0] mem_flash_data_rd;
    logic        mem_flash_done;

    logic        mem_sram_cs;
    logic        mem_sram_rw;
    logic [21:0] mem_sram_addr;
    logic [31:0] mem_sram_data_wr;
    logic [31:0] mem_sram_data_rd;
    logic        mem_sram_done;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err, cpu_busy,
        output mem_flash_cs, mem_flash_rw, mem_flash_addr, mem_flash_data_wr,
        input  mem_flash_data_rd, mem_flash_done,
        output mem_sram_cs, mem_sram_rw, mem_sram_addr, mem_sram_data_wr,
        input  mem_sram_data_rd, mem_sram_done
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err, cpu_busy,
        input  mem_flash_cs, mem_flash_rw, mem_flash_addr, mem_flash_data_wr,
        output mem_flash_data_rd, mem_flash_done,
        input  mem_sram_cs, mem_sram_rw, mem_sram_addr, mem_sram_data_wr,
        output mem_sram_data_rd, mem_sram_done
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// Single-outstanding CPU bridge decoding to SRAM/flash with alignment/decode errors and a WAIT timeout.
// cs one cycle after acceptance, ack one cycle after done (errors ack next cycle); cpu_req ignored while busy.
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_bridge_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        tgt_flash_q;
    logic        we_q;
    logic        err_q;
    logic [15:0] tmo_cnt_q;
    logic [31:0] rdata_q;

    logic        flash_rw_q;
    logic [24:0] flash_addr_q;
    logic [31:0] flash_wdata_q;
    logic        sram_rw_q;
    logic [21:0] sram_addr_q;
    logic [31:0] sram_wdata_q;

    logic align_err, is_sram, is_flash, req_err, sel_done, tmo_hit;

    // Alignment takes priority over decode; both collapse into one error completion.
    assign align_err = (bus.cpu_addr[1:0] != 2'b00);
    assign is_sram   = (bus.cpu_addr[31:24] == 8'h00);
    assign is_flash  = (bus.cpu_addr[31:27] == 5'b10000);
    assign req_err   = align_err || !(is_sram || is_flash);
    assign sel_done  = tgt_flash_q ? bus.mem_flash_done : bus.mem_sram_done;
    assign tmo_hit   = (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cpu_req) state_d = req_err ? RESP : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (sel_done || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_flash_cs = 1'b0;
        bus.mem_sram_cs  = 1'b0;
        bus.cpu_ack      = 1'b0;
        bus.cpu_err      = 1'b0;
        bus.cpu_busy     = (state_q != IDLE);
        case (state_q)
            ISSUE: begin
                bus.mem_flash_cs = tgt_flash_q;
                bus.mem_sram_cs  = !tgt_flash_q;
            end
            RESP: begin
                bus.cpu_ack = 1'b1;
                bus.cpu_err = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_flash_q   <= 1'b0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            tmo_cnt_q     <= '0;
            rdata_q       <= '0;
            flash_rw_q    <= 1'b0;
            flash_addr_q  <= '0;
            flash_wdata_q <= '0;
            sram_rw_q     <= 1'b0;
            sram_addr_q   <= '0;
            sram_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req) begin
                        err_q   <= req_err;
                        rdata_q <= '0;
                        // Target buses only move on a valid request, so each holds its last command.
                        if (!req_err) begin
                            we_q        <= bus.cpu_we;
                            tgt_flash_q <= is_flash;
                            if (is_flash) begin
                                flash_rw_q    <= bus.cpu_we;
                                flash_addr_q  <= bus.cpu_addr[26:2];
                                flash_wdata_q <= bus.cpu_wdata;
                            end else begin
                                sram_rw_q     <= bus.cpu_we;
                                sram_addr_q   <= bus.cpu_addr[23:2];
                                sram_wdata_q  <= bus.cpu_wdata;
                            end
                        end
                    end
                end
                ISSUE: tmo_cnt_q <= '0;
                WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (sel_done) begin
                        if (!we_q) begin
                            rdata_q <= tgt_flash_q ? bus.mem_flash_data_rd : bus.mem_sram_data_rd;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_rdata         = rdata_q;
    assign bus.mem_flash_rw      = flash_rw_q;
    assign bus.mem_flash_addr    = flash_addr_q;
    assign bus.mem_flash_data_wr = flash_wdata_q;
    assign bus.mem_sram_rw       = sram_rw_q;
    assign bus.mem_sram_addr     = sram_addr_q;
    assign bus.mem_sram_data_wr  = sram_wdata_q;
endmodule
